// File: rtl/frame_fetch_reader.sv
// AXI4 read master that fetches one frame in fixed INCR bursts and forwards
// the read data as an AXI-Stream, rotating TDEST across image processors per burst.
module frame_fetch_reader #(
   parameter int unsigned IP_AMT       = 1,
   parameter int unsigned DATA_W       = 256,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned AXI_ID_W     = 4,
   parameter int unsigned AXI_ID       = 0,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned FRAME_BEATS  = 64,
   parameter int unsigned AXIS_TID_W   = 2,
   parameter int unsigned AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [ADDR_W-1:0]         frame_base_i,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic                      err_o,
   output logic [AXI_ID_W-1:0]       m_arid_o,
   output logic [ADDR_W-1:0]         m_araddr_o,
   output logic [7:0]                m_arlen_o,
   output logic [2:0]                m_arsize_o,
   output logic [1:0]                m_arburst_o,
   output logic                      m_arvalid_o,
   input  logic                      m_arready_i,
   input  logic [AXI_ID_W-1:0]       m_rid_i,
   input  logic [DATA_W-1:0]         m_rdata_i,
   input  logic [1:0]                m_rresp_i,
   input  logic                      m_rlast_i,
   input  logic                      m_rvalid_i,
   output logic                      m_rready_o,
   output logic [AXIS_TID_W-1:0]     m_tid_o,
   output logic [AXIS_TDEST_W-1:0]   m_tdest_o,
   output logic [DATA_W-1:0]         m_tdata_o,
   output logic [DATA_W/8-1:0]       m_tkeep_o,
   output logic [DATA_W/8-1:0]       m_tstrb_o,
   output logic                      m_tlast_o,
   output logic                      m_tvalid_o,
   input  logic                      m_tready_i
);

   localparam int unsigned NumBursts = FRAME_BEATS / BURST_LEN;
   localparam int unsigned BeatW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned BurstW    = (NumBursts > 1) ? $clog2(NumBursts) : 1;
   localparam int unsigned Bytes     = DATA_W / 8;

   localparam logic [BeatW-1:0]        LastBeat   = BeatW'(BURST_LEN - 1);
   localparam logic [BurstW-1:0]       LastBurst  = BurstW'(NumBursts - 1);
   localparam logic [AXIS_TDEST_W-1:0] LastDest   = AXIS_TDEST_W'(IP_AMT - 1);
   localparam logic [ADDR_W-1:0]       BurstBytes = ADDR_W'(BURST_LEN * Bytes);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

   state_e                    state_q;
   logic                      busy_q, frame_done_q, err_q, arvalid_q;
   logic [ADDR_W-1:0]         araddr_q;
   logic [BeatW-1:0]          beat_q;
   logic [BurstW-1:0]         burst_q;
   logic [AXIS_TID_W-1:0]     tid_q;
   logic [AXIS_TDEST_W-1:0]   tdest_q;

   logic in_data, xfer, beat_last, burst_last;
   logic unused_rid;

   assign unused_rid = ^m_rid_i;
   assign in_data    = (state_q == StData);
   assign xfer       = in_data & m_rvalid_i & m_tready_i;
   assign beat_last  = (beat_q == LastBeat);
   assign burst_last = (burst_q == LastBurst);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         beat_q       <= '0;
         burst_q      <= '0;
         tid_q        <= '0;
         tdest_q      <= '0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  araddr_q  <= frame_base_i;
                  arvalid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  err_q     <= 1'b0;
                  beat_q    <= '0;
                  burst_q   <= '0;
                  tdest_q   <= '0;
                  state_q   <= StAddr;
               end
            end
            StAddr: begin
               if (m_arready_i) begin
                  arvalid_q <= 1'b0;
                  state_q   <= StData;
               end
            end
            StData: begin
               if (xfer) begin
                  // Burst length is owned by beat_q; RLAST is only cross-checked.
                  if ((m_rresp_i != 2'b00) || (m_rlast_i != beat_last)) err_q <= 1'b1;
                  if (beat_last) begin
                     beat_q  <= '0;
                     tdest_q <= (tdest_q == LastDest) ? '0 : tdest_q + 1'b1;
                     if (burst_last) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= StDone;
                     end else begin
                        burst_q   <= burst_q + 1'b1;
                        araddr_q  <= araddr_q + BurstBytes;
                        arvalid_q <= 1'b1;
                        state_q   <= StAddr;
                     end
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            StDone: begin
               tid_q   <= tid_q + 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign err_o        = err_q;

   assign m_arid_o    = AXI_ID_W'(AXI_ID);
   assign m_araddr_o  = araddr_q;
   assign m_arlen_o   = 8'(BURST_LEN - 1);
   assign m_arsize_o  = 3'($clog2(Bytes));
   assign m_arburst_o = 2'b01;
   assign m_arvalid_o = arvalid_q;

   // Zero-latency pass-through, only open while a burst is being received.
   assign m_rready_o = in_data & m_tready_i;
   assign m_tvalid_o = in_data & m_rvalid_i;
   assign m_tdata_o  = in_data ? m_rdata_i : '0;
   assign m_tlast_o  = in_data & burst_last & beat_last;
   assign m_tkeep_o  = '1;
   assign m_tstrb_o  = '1;
   assign m_tid_o    = tid_q;
   assign m_tdest_o  = tdest_q;

endmodule

// File: doc/frame_fetch_reader.md
Name: frame_fetch_reader

Overview:
- AXI4 read master that fetches one frame of pixel groups from frame memory in fixed-length INCR bursts.
- Re-emits the fetched data as an AXI-Stream, tagging each burst with a round-robin TDEST (image-processor index).
- Sits directly upstream of the AXI-Stream to image-processor dispatcher, and drives its s_t* inputs.
- Software or the sensor front end triggers one frame per start pulse.

Parameters:
- IP_AMT, 1, number of image processors; TDEST rotates 0..IP_AMT-1.
- DATA_W, 256, AXI R data and TDATA width in bits; power of 2, 8..1024.
- ADDR_W, 32, AXI address width.
- AXI_ID_W, 4, ARID/RID width.
- AXI_ID, 0, constant ARID value.
- BURST_LEN, 16, beats per burst; range 1..256.
- FRAME_BEATS, 64, beats per frame; must be an integer multiple of BURST_LEN.
- AXIS_TID_W, 2, TID width.
- AXIS_TDEST_W, max(clog2(IP_AMT),1), TDEST width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  frame start pulse; honoured only while idle.
- frame_base_i  in  ADDR_W  frame byte base address; sampled when start is accepted; must be aligned to DATA_W/8.
- busy_o  out  1  high from start accept until frame completion.
- frame_done_o  out  1  one-cycle pulse after the last beat of a frame is transferred.
- err_o  out  1  sticky error flag; cleared only by rst or by an accepted start.
- m_arid_o  out  AXI_ID_W  constant AXI_ID.
- m_araddr_o  out  ADDR_W  burst start address.
- m_arlen_o  out  8  constant BURST_LEN-1.
- m_arsize_o  out  3  constant log2(DATA_W/8).
- m_arburst_o  out  2  constant 2'b01 (INCR).
- m_arvalid_o  out  1  address valid.
- m_arready_i  in  1  address ready.
- m_rid_i  in  AXI_ID_W  read ID; ignored.
- m_rdata_i  in  DATA_W  read data.
- m_rresp_i  in  2  read response.
- m_rlast_i  in  1  last beat of burst.
- m_rvalid_i  in  1  read valid.
- m_rready_o  out  1  read ready.
- m_tid_o  out  AXIS_TID_W  frame counter, modulo 2^AXIS_TID_W.
- m_tdest_o  out  AXIS_TDEST_W  target image processor.
- m_tdata_o  out  DATA_W  pixel group.
- m_tkeep_o  out  DATA_W/8  all ones.
- m_tstrb_o  out  DATA_W/8  all ones.
- m_tlast_o  out  1  last beat of the frame.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.

Behaviour:
- Reset values: state IDLE; busy_o=0, frame_done_o=0, err_o=0, m_arvalid_o=0, m_araddr_o=0, m_rready_o=0, m_tvalid_o=0, m_tlast_o=0, m_tid_o=0, m_tdest_o=0. Burst counter, beat counter and frame counter all reset to 0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - start_i=1 -> latch frame_base_i; clear err_o, burst_idx, beat_cnt and the TDEST counter; set busy_o; go to ADDR.
  - start_i while busy is ignored.
- ADDR:
  - m_arvalid_o=1 (registered).
  - m_araddr_o = base + burst_idx*BURST_LEN*(DATA_W/8), computed in ADDR_W bits; wrap-around is modulo 2^ADDR_W.
  - m_arvalid_o and m_araddr_o stay stable until m_arready_i. On handshake -> DATA.
  - Exactly one burst outstanding at a time.
- DATA: R-to-stream pass-through with zero latency:
  - m_tdata_o = m_rdata_i.
  - m_tvalid_o = m_rvalid_i.
  - m_rready_o = m_tready_i.
  - All three are gated by state==DATA; outside DATA, m_tvalid_o=0 and m_rready_o=0.
- Beat transfer = m_rvalid_i & m_tready_i in DATA; on each transfer beat_cnt increments.
- m_tlast_o=1 on the beat where burst_idx==FRAME_BEATS/BURST_LEN-1 and beat_cnt==BURST_LEN-1.
- Error conditions set err_o; the data beat is still forwarded unchanged:
  - m_rresp_i != 2'b00 on any transferred beat.
  - m_rlast_i disagrees with (beat_cnt==BURST_LEN-1).
- Burst end is decided by beat_cnt only, never by m_rlast_i. On the final beat of a burst:
  - beat_cnt<=0; TDEST <= (TDEST==IP_AMT-1) ? 0 : TDEST+1.
  - If last burst of frame -> DONE; else burst_idx++ and -> ADDR.
- DONE:
  - frame_done_o=1 for one cycle; busy_o drops the same cycle.
  - m_tid_o increments (wraps); -> IDLE.
  - A start in the cycle after DONE is accepted.
- IP_AMT=1: m_tdest_o is constantly 0.
- Backpressure: m_tready_i=0 holds m_rready_o=0, with no loss or duplication of data.
- Reset mid-operation forces all outputs to reset values immediately. In-flight AXI bursts are abandoned; the system resets the interconnect together with this block.

Test Plan:
- Defaults, frame_base_i=0x1000, start pulse, m_arready_i=1, R always valid, m_tready_i=1 -> 4 AR with araddr 0x1000, 0x1200, 0x1400, 0x1600; arlen=15, arsize=5, arburst=1. 64 beats out, tlast only on beat 63; frame_done_o pulses once; m_tid_o goes 0->1.
- IP_AMT=3, same frame -> tdest per burst is 0, 1, 2, 0; each burst's 16 beats carry a constant tdest.
- m_tready_i toggling on a random 50% pattern -> m_rready_o mirrors m_tready_i; data sequence 0..63 is received in order with no drops or repeats.
- Beat 5 of burst 1 with rresp=2'b10 -> err_o=1 and stays 1 through frame_done_o; the data is still forwarded; the next accepted start clears err_o.
- m_rlast_i asserted on beat 14 of a burst -> err_o=1; the burst still ends after beat 15; 64 beats total.
- rst asserted during burst 2 in DATA -> outputs return to reset values that cycle. start_i during busy is ignored; a new start after reset restarts at frame_base_i with tid=0.
